// File: rtl/alu_pipe_if.sv
// Operand-issue / result-writeback handshake bundle for alu_pipe.
// With ALU_PIPE_SAT_EN defined the bundle also carries the per-operation sat_mode bit.
interface alu_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
`ifdef ALU_PIPE_SAT_EN
  logic             sat_mode;

  modport master (
    output in_valid, in_op, in_a, in_b, sat_mode, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, sat_mode, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
`else
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
`endif
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready backpressure on both sides and {N,Z,C,V} flags.
// Optional unsigned saturation of ADD/SUB is enabled by defining ALU_PIPE_SAT_EN.
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input logic       clk,
  input logic       reset,
  alu_pipe_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] WIDTH_L = (SHW + 1)'(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_AND    = 3'b010,
    OP_OR     = 3'b011,
    OP_XOR    = 3'b100,
    OP_SLL    = 3'b101,
    OP_SRL    = 3'b110,
    OP_PASS_B = 3'b111
  } op_e;

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
`ifdef ALU_PIPE_SAT_EN
  logic             s1_sat;
`endif

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic [3:0]       s2_flags;

  logic             s1_adv;
  logic             s2_adv;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [SHW-1:0]   shamt;
  logic             shift_oob;
  logic [WIDTH-1:0] res;
  logic             c_flag;
  logic             v_flag;

  // A stage may load when it is empty or its contents move on this cycle; no skid buffer.
  assign s2_adv       = ~s2_valid | bus.out_ready;
  assign s1_adv       = ~s1_valid | s2_adv;
  assign bus.in_ready = s1_adv;

  assign bus.out_valid  = s2_valid;
  assign bus.out_result = s2_result;
  assign bus.out_flags  = s2_flags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
`ifdef ALU_PIPE_SAT_EN
      s1_sat   <= 1'b0;
`endif
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op  <= op_e'(bus.in_op);
        s1_a   <= bus.in_a;
        s1_b   <= bus.in_b;
`ifdef ALU_PIPE_SAT_EN
        s1_sat <= bus.sat_mode;
`endif
      end
    end
  end

  // Arithmetic is one bit wider so the top bit is the raw carry (ADD) or borrow (SUB).
  assign sum_ext   = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff_ext  = {1'b0, s1_a} - {1'b0, s1_b};
  assign shamt     = s1_b[SHW-1:0];
  assign shift_oob = {1'b0, shamt} >= WIDTH_L;

  always_comb begin
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res    = sum_ext[WIDTH-1:0];
        c_flag = sum_ext[WIDTH];
        v_flag = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum_ext[WIDTH-1] != s1_a[WIDTH-1]);
`ifdef ALU_PIPE_SAT_EN
        if (s1_sat && c_flag) res = '1;
`endif
      end
      OP_SUB: begin
        res    = diff_ext[WIDTH-1:0];
        c_flag = diff_ext[WIDTH];
        v_flag = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff_ext[WIDTH-1] != s1_a[WIDTH-1]);
`ifdef ALU_PIPE_SAT_EN
        if (s1_sat && c_flag) res = '0;
`endif
      end
      OP_AND:    res = s1_a & s1_b;
      OP_OR:     res = s1_a | s1_b;
      OP_XOR:    res = s1_a ^ s1_b;
      OP_SLL:    res = shift_oob ? '0 : (s1_a << shamt);
      OP_SRL:    res = shift_oob ? '0 : (s1_a >> shamt);
      OP_PASS_B: res = s1_b;
      default:   res = '0;
    endcase
  end

  // N and Z are taken from the final (possibly saturated) result so flags match out_result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= res;
        s2_flags  <= {res[WIDTH-1], (res == '0), c_flag, v_flag};
      end
    end
  end

endmodule
